// File: rtl/mod12_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mod12_seq_ctrl_if
//
// Requester-side bundle for mod12_seq_ctrl: two valid/ready command channels
// (A and B) plus the command-completion report.
//
//   a_valid / b_valid  command valid from requester A / B
//   a_op    / b_op     opcode: 00 NOP, 01 LOAD, 10 UP, 11 DOWN
//   a_arg   / b_arg    LOAD value, or step count for UP/DOWN
//   a_ready / b_ready  command accepted this cycle
//   done               one-cycle completion pulse
//   done_id            owner of the completed command (0 = A, 1 = B)
//   done_val           counter value at completion
//   done_err           LOAD rejected (argument above terminal count)
//
// Modports: master = requester side, slave = the sequencer.
// -----------------------------------------------------------------------------
interface mod12_seq_ctrl_if;
  logic       a_valid;
  logic [1:0] a_op;
  logic [3:0] a_arg;
  logic       a_ready;

  logic       b_valid;
  logic [1:0] b_op;
  logic [3:0] b_arg;
  logic       b_ready;

  logic       done;
  logic       done_id;
  logic [3:0] done_val;
  logic       done_err;

  modport master (
    output a_valid, a_op, a_arg,
    input  a_ready,
    output b_valid, b_op, b_arg,
    input  b_ready,
    input  done, done_id, done_val, done_err
  );

  modport slave (
    input  a_valid, a_op, a_arg,
    output a_ready,
    input  b_valid, b_op, b_arg,
    output b_ready,
    output done, done_id, done_val, done_err
  );
endinterface

// File: rtl/mod12_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mod12_seq_ctrl
//
// Command sequencer and two-port round-robin arbiter in front of a shared
// mod-12 up/down counter. Requesters A and B issue LOAD / UP-N / DOWN-N
// commands; the block steers the counter's load/mode/data inputs and reports
// each completed command with a one-cycle done pulse.
//
// The attached counter steps on every cycle it is not loading, so whenever no
// command is executing the block reloads the counter with its own output to
// hold the value.
//
// Ports:
//   clk        clock, rising edge
//   rstn       synchronous active-low reset (shared with the counter)
//   bus        mod12_seq_ctrl_if.slave: both command channels + done report
//   cnt_dout   current counter value
//   cnt_load   counter load enable
//   cnt_mode   counter direction (0 up, 1 down)
//   cnt_data   counter load value
//   done_wraps wrap events during the command, saturating at 15
//              (present only when MOD12_SEQ_WRAP_CNT_EN is defined)
//
// Parameter:
//   MOD_MAX    terminal count of the attached counter (default 11)
//
// Build option: define MOD12_SEQ_WRAP_CNT_EN to add the done_wraps output.
// -----------------------------------------------------------------------------
module mod12_seq_ctrl #(
  parameter int MOD_MAX = 11
) (
  input  logic                 clk,
  input  logic                 rstn,
  mod12_seq_ctrl_if.slave      bus,
  input  logic [3:0]           cnt_dout,
  output logic                 cnt_load,
  output logic                 cnt_mode,
  output logic [3:0]           cnt_data
`ifdef MOD12_SEQ_WRAP_CNT_EN
  ,
  output logic [3:0]           done_wraps
`endif
);

  localparam logic [3:0] MAX4 = MOD_MAX[3:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic       prio_q,  prio_d;   // 0: A has priority, 1: B has priority
  logic [3:0] step_q,  step_d;   // remaining UP/DOWN steps
  op_t        op_q,    op_d;     // latched opcode
  logic [3:0] arg_q,   arg_d;    // latched argument
  logic       id_q,    id_d;     // latched owner
  logic       err_q,   err_d;    // latched reject flag

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic       grant_a, grant_b;
  logic       idle_ok;
  logic       accept;
  op_t        sel_op;
  logic [3:0] sel_arg;

  // The contending requester wins only when prio points at it; a lone valid
  // always wins. At most one grant can be high.
  assign grant_a = bus.a_valid & (~bus.b_valid | ~prio_q);
  assign grant_b = bus.b_valid & (~bus.a_valid |  prio_q);

  // Ready is forced low while reset is asserted, even though state_q may not
  // have reached IDLE yet on the first reset edge.
  assign idle_ok     = (state_q == S_IDLE) & rstn;
  assign bus.a_ready = idle_ok & grant_a;
  assign bus.b_ready = idle_ok & grant_b;
  assign accept      = bus.a_ready | bus.b_ready;

  assign sel_op  = bus.b_ready ? op_t'(bus.b_op) : op_t'(bus.a_op);
  assign sel_arg = bus.b_ready ? bus.b_arg       : bus.a_arg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    step_d  = step_q;
    op_d    = op_q;
    arg_d   = arg_q;
    id_d    = id_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          id_d   = bus.b_ready;
          prio_d = ~bus.b_ready;      // priority passes to the other side
          op_d   = sel_op;
          arg_d  = sel_arg;
          err_d  = 1'b0;
          step_d = 4'd0;
          unique case (sel_op)
            OP_LOAD: begin
              if (sel_arg > MAX4) begin
                // Out-of-range load: report the error, leave the counter alone.
                err_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d = S_EXEC;
              end
            end
            OP_UP, OP_DOWN: begin
              if (sel_arg != 4'd0) begin
                step_d  = sel_arg;
                state_d = S_EXEC;
              end else begin
                state_d = S_DONE;
              end
            end
            default: state_d = S_DONE; // NOP
          endcase
        end
      end

      S_EXEC: begin
        if (op_q == OP_LOAD) begin
          state_d = S_DONE;
        end else begin
          // Leave after the cycle that issues the last step.
          step_d = step_q - 4'd1;
          if (step_q <= 4'd1) state_d = S_DONE;
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      step_q  <= 4'd0;
      op_q    <= OP_NOP;
      arg_q   <= 4'd0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      step_q  <= step_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter drive
  // ---------------------------------------------------------------------------
  // Default is the hold drive: reload the counter with its own value.
  always_comb begin
    cnt_load = 1'b1;
    cnt_mode = 1'b0;
    cnt_data = cnt_dout;
    if (state_q == S_EXEC) begin
      if (op_q == OP_LOAD) begin
        cnt_data = arg_q;
      end else begin
        cnt_load = 1'b0;
        cnt_mode = (op_q == OP_DOWN);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion report
  // ---------------------------------------------------------------------------
  assign bus.done     = (state_q == S_DONE);
  assign bus.done_id  = id_q;
  assign bus.done_val = bus.done ? cnt_dout : 4'd0;
  assign bus.done_err = bus.done & err_q;

`ifdef MOD12_SEQ_WRAP_CNT_EN
  // ---------------------------------------------------------------------------
  // Wrap counter: an EXEC step taken from the terminal value while counting up,
  // or from zero while counting down, is a wrap on the following edge.
  // ---------------------------------------------------------------------------
  logic [3:0] wraps_q, wraps_d;
  logic       wrap_evt;

  assign wrap_evt = ((op_q == OP_UP)   && (cnt_dout == MAX4)) ||
                    ((op_q == OP_DOWN) && (cnt_dout == 4'd0));

  always_comb begin
    wraps_d = wraps_q;
    if (state_q == S_IDLE && accept) begin
      wraps_d = 4'd0;
    end else if (state_q == S_EXEC && wrap_evt && wraps_q != 4'hF) begin
      wraps_d = wraps_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) wraps_q <= 4'd0;
    else       wraps_q <= wraps_d;
  end

  assign done_wraps = wraps_q;
`endif

endmodule

// File: tb/tb_mod12_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mod12_seq_ctrl
//
// Directed bench for mod12_seq_ctrl with a behavioural mod-12 up/down counter
// attached. Each scenario task drives its own stimulus and compares against
// hand-computed values. Define MOD12_SEQ_WRAP_CNT_EN to also check done_wraps.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mod12_seq_ctrl;

  logic       clk;
  logic       rstn;
  logic [3:0] cnt;
  logic       cnt_load;
  logic       cnt_mode;
  logic [3:0] cnt_data;
`ifdef MOD12_SEQ_WRAP_CNT_EN
  logic [3:0] done_wraps;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] seq_log [0:31];

  mod12_seq_ctrl_if bus ();

  mod12_seq_ctrl #(.MOD_MAX(11)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .cnt_dout (cnt),
    .cnt_load (cnt_load),
    .cnt_mode (cnt_mode),
    .cnt_data (cnt_data)
`ifdef MOD12_SEQ_WRAP_CNT_EN
    ,
    .done_wraps (done_wraps)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference mod-12 counter sharing rstn with the sequencer.
  always @(posedge clk) begin
    if (!rstn)          cnt <= 4'd0;
    else if (cnt_load)  cnt <= cnt_data;
    else if (cnt_mode)  cnt <= (cnt == 4'd0)  ? 4'd11 : cnt - 4'd1;
    else                cnt <= (cnt == 4'd11) ? 4'd0  : cnt + 4'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one command and wait (bounded) for its ready; returns just after
  // the acceptance edge with valid dropped.
  task automatic send(input logic id, input logic [1:0] op, input logic [3:0] arg,
                      output logic acc);
    acc = 1'b0;
    @(negedge clk);
    if (id) begin bus.b_valid = 1'b1; bus.b_op = op; bus.b_arg = arg; end
    else    begin bus.a_valid = 1'b1; bus.a_op = op; bus.a_arg = arg; end
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (id ? bus.b_ready : bus.a_ready) acc = 1'b1;
      else @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  // Bounded wait for done; lat counts cycles after the acceptance cycle
  // (-1 on timeout). seq_log[k] holds the counter value seen in cycle T+k.
  task automatic wait_done(input int max_cyc, output int lat, output logic [3:0] val,
                           output logic id, output logic err, output logic [3:0] wr);
    lat = -1; val = 4'd0; id = 1'b0; err = 1'b0; wr = 4'd0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      seq_log[k] = cnt;
      if (bus.done) begin
        lat = k; val = bus.done_val; id = bus.done_id; err = bus.done_err;
`ifdef MOD12_SEQ_WRAP_CNT_EN
        wr = done_wraps;
`endif
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    bus.a_valid = 1'b1; bus.a_op = 2'b00; bus.a_arg = 4'd0;
    #1;
    vectors++; if (bus.a_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", bus.a_ready); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
    vectors++; if (bus.done_id !== 1'b0 || bus.done_err !== 1'b0) begin miscompares++; $display("FAIL reset_id_err: got %b/%b want 0/0", bus.done_id, bus.done_err); end
    vectors++; if (cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    @(negedge clk);
    bus.a_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    vectors++; if (cnt !== 4'd0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_hold: cnt %0d done %b want 0/0", cnt, bus.done); end
  endtask

  task automatic test_round_robin();
    logic exp_a, exp_b, exp_done;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.a_valid = 1'b1; bus.a_op = 2'b00; bus.a_arg = 4'd0;
        bus.b_valid = 1'b1; bus.b_op = 2'b00; bus.b_arg = 4'd0;
      end
      #1;
      exp_a    = (c % 4 == 0);
      exp_b    = (c % 4 == 2);
      exp_done = (c % 2 == 1);
      vectors++; if (bus.a_ready & bus.b_ready) begin miscompares++; $display("FAIL rr_both_ready: cycle %0d both readys high", c); end
      vectors++; if ({bus.a_ready, bus.b_ready} !== {exp_a, exp_b}) begin miscompares++; $display("FAIL rr_grant: cycle %0d got a=%b b=%b want a=%b b=%b", c, bus.a_ready, bus.b_ready, exp_a, exp_b); end
      vectors++; if (bus.done !== exp_done) begin miscompares++; $display("FAIL rr_done: cycle %0d got %b want %b", c, bus.done, exp_done); end
      if (exp_done) begin
        vectors++; if (bus.done_id !== (c % 4 == 3)) begin miscompares++; $display("FAIL rr_done_id: cycle %0d got %b want %b", c, bus.done_id, (c % 4 == 3)); end
      end
    end
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    vectors++; if (cnt !== 4'd0) begin miscompares++; $display("FAIL rr_cnt_hold: got %0d want 0", cnt); end
  endtask

  task automatic test_load_up();
    logic acc; int lat; logic [3:0] val, wr; logic id, err;
    logic [3:0] exp_seq [0:5];
    exp_seq = '{4'd9, 4'd10, 4'd11, 4'd0, 4'd1, 4'd2};
    send(1'b0, 2'b01, 4'd9, acc);
    vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL load9_accept: got %b want 1", acc); end
    wait_done(10, lat, val, id, err, wr);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL load9_latency: got %0d want 2", lat); end
    vectors++; if (val !== 4'd9 || id !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL load9_report: val %0d id %b err %b want 9/0/0", val, id, err); end
    vectors++; if (cnt !== 4'd9) begin miscompares++; $display("FAIL load9_cnt: got %0d want 9", cnt); end
    send(1'b0, 2'b10, 4'd5, acc);
    vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL up5_accept: got %b want 1", acc); end
    wait_done(20, lat, val, id, err, wr);
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL up5_latency: got %0d want 6", lat); end
    vectors++; if (val !== 4'd2 || id !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL up5_report: val %0d id %b err %b want 2/0/0", val, id, err); end
    if (lat == 6) begin
      for (int k = 1; k <= 6; k++) begin
        vectors++; if (seq_log[k] !== exp_seq[k-1]) begin miscompares++; $display("FAIL up5_seq: cycle T+%0d got %0d want %0d", k, seq_log[k], exp_seq[k-1]); end
      end
    end
`ifdef MOD12_SEQ_WRAP_CNT_EN
    vectors++; if (wr !== 4'd1) begin miscompares++; $display("FAIL up5_wraps: got %0d want 1", wr); end
`endif
    @(negedge clk);
    vectors++; if (bus.done !== 1'b0 || cnt !== 4'd2) begin miscompares++; $display("FAIL up5_after: done %b cnt %0d want 0/2", bus.done, cnt); end
  endtask

  task automatic test_down_zero();
    logic acc; int lat; logic [3:0] val, wr; logic id, err;
    logic [3:0] exp_seq [0:3];
    exp_seq = '{4'd1, 4'd0, 4'd11, 4'd10};
    send(1'b1, 2'b01, 4'd1, acc);
    wait_done(10, lat, val, id, err, wr);
    vectors++; if (lat !== 2 || val !== 4'd1 || id !== 1'b1) begin miscompares++; $display("FAIL load1: lat %0d val %0d id %b want 2/1/1", lat, val, id); end
    send(1'b1, 2'b11, 4'd3, acc);
    vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL down3_accept: got %b want 1", acc); end
    wait_done(20, lat, val, id, err, wr);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL down3_latency: got %0d want 4", lat); end
    vectors++; if (val !== 4'd10 || id !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL down3_report: val %0d id %b err %b want 10/1/0", val, id, err); end
    if (lat == 4) begin
      for (int k = 1; k <= 4; k++) begin
        vectors++; if (seq_log[k] !== exp_seq[k-1]) begin miscompares++; $display("FAIL down3_seq: cycle T+%0d got %0d want %0d", k, seq_log[k], exp_seq[k-1]); end
      end
    end
`ifdef MOD12_SEQ_WRAP_CNT_EN
    vectors++; if (wr !== 4'd1) begin miscompares++; $display("FAIL down3_wraps: got %0d want 1", wr); end
`endif
  endtask

  task automatic test_reject();
    logic acc; int lat; logic [3:0] val, wr; logic id, err;
    send(1'b0, 2'b01, 4'd13, acc);
    vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL rej_accept: got %b want 1", acc); end
    wait_done(10, lat, val, id, err, wr);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL rej_latency: got %0d want 1", lat); end
    vectors++; if (err !== 1'b1 || val !== 4'd10) begin miscompares++; $display("FAIL rej_report: err %b val %0d want 1/10", err, val); end
    @(negedge clk);
    vectors++; if (cnt !== 4'd10 || bus.done_err !== 1'b0) begin miscompares++; $display("FAIL rej_after: cnt %0d err %b want 10/0", cnt, bus.done_err); end
  endtask

  task automatic test_zero_hold();
    logic acc; int lat; logic [3:0] val, wr; logic id, err;
    send(1'b0, 2'b10, 4'd0, acc);
    wait_done(10, lat, val, id, err, wr);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL up0_latency: got %0d want 1", lat); end
    vectors++; if (val !== 4'd10 || err !== 1'b0) begin miscompares++; $display("FAIL up0_report: val %0d err %b want 10/0", val, err); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++; if (cnt !== 4'd10) begin miscompares++; $display("FAIL idle_hold: cycle %0d got %0d want 10", c, cnt); end
    end
  endtask

  task automatic test_reset_mid();
    logic acc; int lat; logic [3:0] val, wr; logic id, err;
    int done_seen;
    send(1'b0, 2'b10, 4'd8, acc);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    bus.a_valid = 1'b1; bus.a_op = 2'b00; bus.a_arg = 4'd0;
    @(negedge clk);
    #1;
    vectors++; if (bus.a_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_ready_in_reset: got %b want 0", bus.a_ready); end
    vectors++; if (cnt !== 4'd0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL rmid_state: cnt %0d done %b want 0/0", cnt, bus.done); end
    rstn = 1'b1;
    bus.a_valid = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    vectors++; if (done_seen !== 0) begin miscompares++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_seen); end
    // prio must be back at A even though B held priority before the reset.
    @(negedge clk);
    bus.a_valid = 1'b1; bus.a_op = 2'b00; bus.a_arg = 4'd0;
    bus.b_valid = 1'b1; bus.b_op = 2'b00; bus.b_arg = 4'd0;
    #1;
    vectors++; if ({bus.a_ready, bus.b_ready} !== 2'b10) begin miscompares++; $display("FAIL rmid_prio: got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready); end
    @(posedge clk);
    #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    wait_done(10, lat, val, id, err, wr);
    vectors++; if (lat !== 1 || id !== 1'b0) begin miscompares++; $display("FAIL rmid_nop: lat %0d id %b want 1/0", lat, id); end
    send(1'b0, 2'b01, 4'd4, acc);
    wait_done(10, lat, val, id, err, wr);
    vectors++; if (lat !== 2 || val !== 4'd4 || err !== 1'b0) begin miscompares++; $display("FAIL rmid_load4: lat %0d val %0d err %b want 2/4/0", lat, val, err); end
    @(negedge clk);
    vectors++; if (cnt !== 4'd4) begin miscompares++; $display("FAIL rmid_cnt: got %0d want 4", cnt); end
  endtask

  initial begin
    rstn        = 1'b0;
    bus.a_valid = 1'b0; bus.a_op = 2'b00; bus.a_arg = 4'd0;
    bus.b_valid = 1'b0; bus.b_op = 2'b00; bus.b_arg = 4'd0;
    test_reset();
    test_round_robin();
    test_load_up();
    test_down_zero();
    test_reject();
    test_zero_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mod12_seq_ctrl.md
# mod12_seq_ctrl

Command sequencer and two-port round-robin arbiter for the shared mod-12 up/down counter. Two requesters (A, B) issue LOAD / count-UP-N / count-DOWN-N commands over valid/ready handshakes. The block drives the counter's `load`, `mode` and `data_in` inputs and reads back its `dout`. Because the counter steps on every cycle it is not loading, the block holds the count between commands by reloading `dout`. Each command ends with a one-cycle `done` pulse carrying the resulting count.

## Interface
- `MOD_MAX`, default 11: terminal count of the attached counter; used for the load range check and wrap detection.
- `clk`  in  1  clock; all state updates on rising edge.
- `rstn`  in  1  reset; synchronous, active-low. Shared with the counter.
- `a_valid`  in  1  requester A command valid.
- `a_op`  in  2  A opcode: 00 NOP, 01 LOAD, 10 UP, 11 DOWN.
- `a_arg`  in  4  A argument: the load value for LOAD, the step count for UP/DOWN.
- `a_ready`  out  1  A command accepted this cycle.
- `b_valid`, `b_op`, `b_arg`, `b_ready`: same as the A signals, for requester B.
- `cnt_dout`  in  4  current counter value.
- `cnt_load`  out  1  drives counter `load`.
- `cnt_mode`  out  1  drives counter `mode` (0 up, 1 down).
- `cnt_data`  out  4  drives counter `data_in`.
- `done`  out  1  one-cycle command-completion pulse.
- `done_id`  out  1  requester that owned the completed command (0 = A, 1 = B).
- `done_val`  out  4  `cnt_dout` sampled in the DONE cycle.
- `done_err`  out  1  LOAD rejected because `arg > MOD_MAX`.

## Operation
- **States:** IDLE, EXEC, DONE.
- **Hold drive** (IDLE and DONE): `cnt_load=1`, `cnt_data=cnt_dout`, `cnt_mode=0`. The counter value is unchanged.
- **IDLE arbitration:**
  - Only the winner's ready is asserted. `x_ready = x_valid & winner`, combinational; at most one ready is high per cycle.
  - Round-robin priority register `prio`. If both requesters are valid, the one `prio` points at wins.
  - On acceptance, `prio` moves to the other requester, and `op`/`arg`/id are latched.
- **Transitions on acceptance:**
  - LOAD with `arg <= MOD_MAX` → EXEC.
  - LOAD with `arg > MOD_MAX` → DONE with `err=1`; the counter is untouched.
  - UP/DOWN with `arg != 0` → EXEC, with step counter = `arg`.
  - UP/DOWN with `arg = 0`, and NOP → DONE directly.
- **EXEC behaviour:**
  - LOAD: `cnt_load=1`, `cnt_data=arg` for exactly one cycle, then → DONE.
  - UP/DOWN: `cnt_load=0`, `cnt_mode=0` for UP or 1 for DOWN. The step counter decrements each cycle; → DONE in the cycle it reaches 1.
  - Wrap-around is the counter's job (11→0 up, 0→11 down); the block does not intervene.
- **DONE:** `done=1` for one cycle with `done_id`, `done_val=cnt_dout`, `done_err`; → IDLE.
- **No new command is accepted in EXEC or DONE**; ready stays 0 there.
- **No preemption:** a valid from the other requester waits until IDLE.

## Timing
- Accept at cycle T.
  - LOAD: EXEC at T+1, counter updated at the end of T+1, `done` at T+2.
  - UP/DOWN N: EXEC at T+1..T+N, `done` at T+N+1.
  - NOP, zero-step, or rejected LOAD: `done` at T+1.
- Minimum spacing between accepts is 2 cycles (DONE, then IDLE).
- **Reset** (rstn low at an edge):
  - state → IDLE, `prio` → A, step counter → 0, latched command cleared, `done=0`, `done_err=0`, `done_id=0`.
  - During reset both readys are forced to 0.
- **Reset mid-command:** the command is aborted and no `done` is issued. The counter itself resets to 0 through the shared rstn.
- `done_val` equals the post-command counter value.

## Configuration
- `MOD12_SEQ_WRAP_CNT_EN` defined:
  - Adds output `done_wraps` [3:0]: the number of wrap events during the command, counting 11→0 in UP and 0→11 in DOWN.
  - Reset to 0 at acceptance; valid in the DONE cycle; saturates at 15.
- `MOD12_SEQ_WRAP_CNT_EN` undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- **Load then count up:** after reset, A issues LOAD 9; then A issues UP 5. Required:
  - counter 9 after LOAD, with `done_val=9`;
  - count sequence 10, 11, 0, 1, 2;
  - `done` at T+6 with `done_val=2`;
  - `done_wraps=1` if `MOD12_SEQ_WRAP_CNT_EN` is defined.
- **Down across zero:** with the counter at 1, B issues DOWN 3 → sequence 0, 11, 10; `done_id=1`, `done_val=10`.
- **Round-robin:** A and B both hold valid with NOPs for 4 commands. Required:
  - grants alternate A, B, A, B starting from A after reset;
  - never both readys in one cycle;
  - `done` every 2 cycles.
- **Rejected load:** LOAD 13 → `done` at T+1 with `done_err=1`; the counter holds its prior value throughout.
- **Zero step and hold:** UP 0 → `done` at T+1 with `done_val` unchanged. With no requests for 20 cycles the counter value stays constant.
- **Reset mid-command:** rstn low during EXEC of UP 8 → no `done`; state returns to IDLE; counter 0; `prio`=A; the next A LOAD 4 completes normally.
